// File: rtl/prog_load_ctrl.sv
// -----------------------------------------------------------------------------
// prog_load_ctrl
//   Sequences loading of a program into the core's 32-bit instruction memory
//   and arbitrates the single memory port between the JTAG byte loader and
//   the CPU. While a loader session is active the CPU is held in reset.
//   Incoming bytes are packed little-endian into words and each completed
//   word is written once. A trailing partial word is flushed at session end,
//   after which the CPU is released following a fixed hold time.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   jtag_sel_i     loader session active (TCK domain, synchronized here)
//   jtag_we_i      loader byte-valid level (clk_i domain, held several cycles)
//   jtag_data_i    loader byte, stable while jtag_we_i is high
//   jtag_addr_i    loader byte address, stable while jtag_we_i is high
//   cpu_req_i      CPU instruction-fetch request
//   cpu_addr_i     CPU word address
//   cpu_gnt_o      CPU owns the memory port this cycle
//   mem_we_o       memory write strobe, one cycle per word
//   mem_addr_o     memory word address
//   mem_wdata_o    memory write data
//   cpu_rst_o      CPU reset, active high
//   load_done_o    one-cycle pulse on the first RUN cycle after a load
//   words_loaded_o words written in the last/current session (saturating)
// -----------------------------------------------------------------------------
module prog_load_ctrl #(
  parameter int BYTE_ADDR_W = 10,
  parameter int RST_HOLD    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jtag_sel_i,
  input  logic                   jtag_we_i,
  input  logic [7:0]             jtag_data_i,
  input  logic [BYTE_ADDR_W-1:0] jtag_addr_i,
  input  logic                   cpu_req_i,
  input  logic [BYTE_ADDR_W-3:0] cpu_addr_i,
  output logic                   cpu_gnt_o,
  output logic                   mem_we_o,
  output logic [BYTE_ADDR_W-3:0] mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic                   cpu_rst_o,
  output logic                   load_done_o,
  output logic [BYTE_ADDR_W-2:0] words_loaded_o
);

  localparam int WA_W = BYTE_ADDR_W - 2;
  localparam int WL_W = BYTE_ADDR_W - 1;
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Replace one byte lane of a word.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  // Saturating increment of the word counter.
  function automatic logic [WL_W-1:0] sat_inc(input logic [WL_W-1:0] v);
    logic [WL_W-1:0] res;
    if (&v) begin
      res = v;
    end else begin
      res = v + {{(WL_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  state_t state_r, state_nxt_s;

  (* ASYNC_REG = "TRUE" *) logic sel_meta_r;
  (* ASYNC_REG = "TRUE" *) logic sel_sync_r;
  logic             we_q_r;
  logic [7:0]       hold_cnt_r, hold_cnt_nxt_s;
  logic [31:0]      buf_r, buf_nxt_s;
  logic [3:0]       mask_r, mask_nxt_s;
  logic [WA_W-1:0]  waddr_r, waddr_nxt_s;
  logic             pend_r, pend_nxt_s;
  logic [7:0]       pend_data_r, pend_data_nxt_s;
  logic [BYTE_ADDR_W-1:0] pend_addr_r, pend_addr_nxt_s;
  logic             armed_r, armed_nxt_s;
  logic             mem_we_r, mem_we_nxt_s;
  logic [WA_W-1:0]  mem_addr_r, mem_addr_nxt_s;
  logic [31:0]      mem_wdata_r, mem_wdata_nxt_s;
  logic [WL_W-1:0]  words_r, words_nxt_s;
  logic             load_done_r, load_done_nxt_s;
  logic             cpu_rst_r, cpu_rst_nxt_s;

  logic                   cap_s;
  logic                   byte_vld_s;
  logic [7:0]             byte_data_s;
  logic [BYTE_ADDR_W-1:0] byte_addr_s;
  logic [1:0]             lane_s;
  logic [WA_W-1:0]        byte_waddr_s;
  logic [31:0]            merged_s;

  // One capture per loader byte: rising edge of the we level.
  assign cap_s = jtag_we_i & ~we_q_r;

  // Byte source: a byte deferred by an address skip is replayed before any
  // new capture; the loader's we spacing keeps the two from colliding.
  assign byte_vld_s   = pend_r | (cap_s & (state_r == ST_LOAD));
  assign byte_data_s  = pend_r ? pend_data_r : jtag_data_i;
  assign byte_addr_s  = pend_r ? pend_addr_r : jtag_addr_i;
  assign lane_s       = byte_addr_s[1:0];
  assign byte_waddr_s = byte_addr_s[BYTE_ADDR_W-1:2];
  assign merged_s     = merge_byte(buf_r, lane_s, byte_data_s);

  // Next-state, packing and write-issue logic.
  always_comb begin
    state_nxt_s     = state_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    buf_nxt_s       = buf_r;
    mask_nxt_s      = mask_r;
    waddr_nxt_s     = waddr_r;
    pend_nxt_s      = 1'b0;
    pend_data_nxt_s = pend_data_r;
    pend_addr_nxt_s = pend_addr_r;
    armed_nxt_s     = armed_r;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    words_nxt_s     = words_r;
    load_done_nxt_s = 1'b0;

    // Byte packing is shared by LOAD and FLUSH (FLUSH only sees replays).
    if (byte_vld_s) begin
      if ((mask_r != 4'b0000) && (byte_waddr_s != waddr_r)) begin
        // Upstream skipped to another word: retire the partial word first,
        // park the new byte and replay it into a fresh buffer next cycle.
        mem_we_nxt_s    = 1'b1;
        mem_addr_nxt_s  = waddr_r;
        mem_wdata_nxt_s = buf_r;
        words_nxt_s     = sat_inc(words_r);
        buf_nxt_s       = 32'h0000_0000;
        mask_nxt_s      = 4'b0000;
        pend_nxt_s      = 1'b1;
        pend_data_nxt_s = byte_data_s;
        pend_addr_nxt_s = byte_addr_s;
      end else if (lane_s == 2'd3) begin
        mem_we_nxt_s    = 1'b1;
        mem_addr_nxt_s  = byte_waddr_s;
        mem_wdata_nxt_s = merged_s;
        words_nxt_s     = sat_inc(words_r);
        buf_nxt_s       = 32'h0000_0000;
        mask_nxt_s      = 4'b0000;
        waddr_nxt_s     = byte_waddr_s;
      end else begin
        buf_nxt_s   = merged_s;
        mask_nxt_s  = mask_r | (4'b0001 << lane_s);
        waddr_nxt_s = byte_waddr_s;
      end
    end else begin
      buf_nxt_s = buf_r;
    end

    case (state_r)
      ST_HOLD: begin
        if (sel_sync_r) begin
          state_nxt_s    = ST_LOAD;
          hold_cnt_nxt_s = 8'd0;
          buf_nxt_s      = 32'h0000_0000;
          mask_nxt_s     = 4'b0000;
          words_nxt_s    = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s     = ST_RUN;
          hold_cnt_nxt_s  = 8'd0;
          load_done_nxt_s = armed_r;
          armed_nxt_s     = 1'b0;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end
      end
      ST_RUN: begin
        if (sel_sync_r) begin
          state_nxt_s    = ST_LOAD;
          hold_cnt_nxt_s = 8'd0;
          buf_nxt_s      = 32'h0000_0000;
          mask_nxt_s     = 4'b0000;
          words_nxt_s    = '0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        // A capture in the same cycle as the session drop is packed above.
        if (!sel_sync_r) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (byte_vld_s) begin
          state_nxt_s = ST_FLUSH;
        end else if (mask_r != 4'b0000) begin
          // Trailing partial word; absent lanes are already zero in buf_r.
          mem_we_nxt_s    = 1'b1;
          mem_addr_nxt_s  = waddr_r;
          mem_wdata_nxt_s = buf_r;
          words_nxt_s     = sat_inc(words_r);
          buf_nxt_s       = 32'h0000_0000;
          mask_nxt_s      = 4'b0000;
        end else begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = 8'd0;
          armed_nxt_s    = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = ST_HOLD;
        hold_cnt_nxt_s = 8'd0;
      end
    endcase

    cpu_rst_nxt_s = (state_nxt_s != ST_RUN);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_HOLD;
      sel_meta_r  <= 1'b0;
      sel_sync_r  <= 1'b0;
      we_q_r      <= 1'b0;
      hold_cnt_r  <= 8'd0;
      buf_r       <= 32'h0000_0000;
      mask_r      <= 4'b0000;
      waddr_r     <= '0;
      pend_r      <= 1'b0;
      pend_data_r <= 8'h00;
      pend_addr_r <= '0;
      armed_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      words_r     <= '0;
      load_done_r <= 1'b0;
      cpu_rst_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      sel_meta_r  <= jtag_sel_i;
      sel_sync_r  <= sel_meta_r;
      we_q_r      <= jtag_we_i;
      hold_cnt_r  <= hold_cnt_nxt_s;
      buf_r       <= buf_nxt_s;
      mask_r      <= mask_nxt_s;
      waddr_r     <= waddr_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_data_r <= pend_data_nxt_s;
      pend_addr_r <= pend_addr_nxt_s;
      armed_r     <= armed_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      words_r     <= words_nxt_s;
      load_done_r <= load_done_nxt_s;
      cpu_rst_r   <= cpu_rst_nxt_s;
    end
  end

  // In RUN the CPU drives the port address directly so fetches see no
  // extra latency; otherwise the loader's registered write address is used.
  assign mem_addr_o     = (state_r == ST_RUN) ? cpu_addr_i : mem_addr_r;
  assign cpu_gnt_o      = (state_r == ST_RUN) & cpu_req_i;
  assign mem_we_o       = mem_we_r;
  assign mem_wdata_o    = mem_wdata_r;
  assign cpu_rst_o      = cpu_rst_r;
  assign load_done_o    = load_done_r;
  assign words_loaded_o = words_r;

endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;
  localparam int BAW = 10;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           jtag_sel_i;
  logic           jtag_we_i;
  logic [7:0]     jtag_data_i;
  logic [BAW-1:0] jtag_addr_i;
  logic           cpu_req_i;
  logic [BAW-3:0] cpu_addr_i;
  logic           cpu_gnt_o;
  logic           mem_we_o;
  logic [BAW-3:0] mem_addr_o;
  logic [31:0]    mem_wdata_o;
  logic           cpu_rst_o;
  logic           load_done_o;
  logic [BAW-2:0] words_loaded_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // write log filled by the monitor
  int             wr_total   = 0;
  int             dup_cnt    = 0;
  int             run_wr_cnt = 0;
  logic           prev_we    = 1'b0;
  logic [7:0]     prev_addr  = 8'h00;
  logic [7:0]     log_addr [0:63];
  logic [31:0]    log_data [0:63];

  prog_load_ctrl #(.BYTE_ADDR_W(BAW), .RST_HOLD(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .jtag_sel_i     (jtag_sel_i),
    .jtag_we_i      (jtag_we_i),
    .jtag_data_i    (jtag_data_i),
    .jtag_addr_i    (jtag_addr_i),
    .cpu_req_i      (cpu_req_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_gnt_o      (cpu_gnt_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .cpu_rst_o      (cpu_rst_o),
    .load_done_o    (load_done_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  // record every memory write seen at the falling edge
  always @(negedge clk) begin
    prev_we   <= mem_we_o;
    prev_addr <= mem_addr_o;
    if (mem_we_o) begin
      if (wr_total < 64) begin
        log_addr[wr_total] <= mem_addr_o;
        log_data[wr_total] <= mem_wdata_o;
      end
      wr_total <= wr_total + 1;
      if (prev_we && (prev_addr == mem_addr_o)) dup_cnt <= dup_cnt + 1;
      if (!cpu_rst_o) run_wr_cnt <= run_wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [BAW-1:0] a, input logic [7:0] d, input int hold);
    jtag_addr_i = a;
    jtag_data_i = d;
    jtag_we_i   = 1'b1;
    repeat (hold) @(negedge clk);
    jtag_we_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_session();
    jtag_sel_i = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // posedges until cpu_rst_o drops; returns 100 on timeout
  task automatic wait_run(output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!cpu_rst_o) break;
    end
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 60; i++) begin
      if (wr_total >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 8'h05;
    repeat (2) @(negedge clk);
    chk_cnt++; if (cpu_rst_o !== 1'b1) $display("FAIL rst_cpu_rst: got %0h expected 1", cpu_rst_o); else pass_cnt++;
    chk_cnt++; if (mem_we_o !== 1'b0) $display("FAIL rst_mem_we: got %0h expected 0", mem_we_o); else pass_cnt++;
    chk_cnt++; if (cpu_gnt_o !== 1'b0) $display("FAIL rst_gnt: got %0h expected 0", cpu_gnt_o); else pass_cnt++;
    chk_cnt++; if (mem_addr_o !== 8'h00) $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr_o); else pass_cnt++;
    chk_cnt++; if (words_loaded_o !== 9'd0) $display("FAIL rst_words: got %0h expected 0", words_loaded_o); else pass_cnt++;
    chk_cnt++; if (load_done_o !== 1'b0) $display("FAIL rst_done: got %0h expected 0", load_done_o); else pass_cnt++;
    rst_i = 1'b0;
    wait_run(cyc);
    chk_cnt++; if (cyc !== 16) $display("FAIL rst_hold_len: got %0d expected 16", cyc); else pass_cnt++;
    chk_cnt++; if (load_done_o !== 1'b0) $display("FAIL rst_no_done: got %0h expected 0", load_done_o); else pass_cnt++;
    chk_cnt++; if (cpu_gnt_o !== 1'b1) $display("FAIL run_gnt: got %0h expected 1", cpu_gnt_o); else pass_cnt++;
    chk_cnt++; if (mem_addr_o !== 8'h05) $display("FAIL run_mem_addr: got %0h expected 05", mem_addr_o); else pass_cnt++;
    cpu_req_i = 1'b0;
    #1;
    chk_cnt++; if (cpu_gnt_o !== 1'b0) $display("FAIL run_no_req: got %0h expected 0", cpu_gnt_o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    chk_cnt++; if (cpu_rst_o !== 1'b1) $display("FAIL word_cpu_rst: got %0h expected 1", cpu_rst_o); else pass_cnt++;
    send_byte(10'h000, 8'h11, 6);
    send_byte(10'h001, 8'h22, 6);
    send_byte(10'h002, 8'h33, 6);
    send_byte(10'h003, 8'h44, 6);
    repeat (2) @(negedge clk);
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL word_count: got %0d expected 1", wr_total - base); else pass_cnt++;
    chk_cnt++; if (log_addr[base] !== 8'h00) $display("FAIL word_addr: got %0h expected 0", log_addr[base]); else pass_cnt++;
    chk_cnt++; if (log_data[base] !== 32'h4433_2211) $display("FAIL word_data: got %0h expected 44332211", log_data[base]); else pass_cnt++;
    chk_cnt++; if (words_loaded_o !== 9'd1) $display("FAIL word_words: got %0d expected 1", words_loaded_o); else pass_cnt++;
    chk_cnt++; if (cpu_rst_o !== 1'b1) $display("FAIL word_cpu_rst_end: got %0h expected 1", cpu_rst_o); else pass_cnt++;
    jtag_sel_i = 1'b0;
    wait_run(cyc);
    chk_cnt++; if (load_done_o !== 1'b1) $display("FAIL word_done: got %0h expected 1", load_done_o); else pass_cnt++;
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL word_no_flush: got %0d expected 1", wr_total - base); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_partial_flush();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    for (int i = 0; i < 6; i++) send_byte(10'(i), 8'hA0 + 8'(i), 4);
    jtag_sel_i = 1'b0;
    wait_writes(base + 2);
    // flush write seen one HOLD cycle ago; 16 more posedges to RUN
    wait_run(cyc);
    chk_cnt++; if (cyc !== 16) $display("FAIL flush_hold_len: got %0d expected 16", cyc); else pass_cnt++;
    chk_cnt++; if (load_done_o !== 1'b1) $display("FAIL flush_done: got %0h expected 1", load_done_o); else pass_cnt++;
    chk_cnt++; if (log_data[base] !== 32'hA3A2_A1A0) $display("FAIL flush_w0_data: got %0h expected A3A2A1A0", log_data[base]); else pass_cnt++;
    chk_cnt++; if (log_addr[base+1] !== 8'h01) $display("FAIL flush_w1_addr: got %0h expected 1", log_addr[base+1]); else pass_cnt++;
    chk_cnt++; if (log_data[base+1] !== 32'h0000_A5A4) $display("FAIL flush_w1_data: got %0h expected 0000A5A4", log_data[base+1]); else pass_cnt++;
    chk_cnt++; if (words_loaded_o !== 9'd2) $display("FAIL flush_words: got %0d expected 2", words_loaded_o); else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++; if (load_done_o !== 1'b0) $display("FAIL flush_done_pulse: got %0h expected 0", load_done_o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_long_we();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    send_byte(10'h00F, 8'h5A, 20);
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL longwe_count: got %0d expected 1", wr_total - base); else pass_cnt++;
    chk_cnt++; if (log_addr[base] !== 8'h03) $display("FAIL longwe_addr: got %0h expected 3", log_addr[base]); else pass_cnt++;
    chk_cnt++; if (log_data[base] !== 32'h5A00_0000) $display("FAIL longwe_data: got %0h expected 5A000000", log_data[base]); else pass_cnt++;
    jtag_sel_i = 1'b0;
    wait_run(cyc);
    chk_cnt++; if (words_loaded_o !== 9'd1) $display("FAIL longwe_words: got %0d expected 1", words_loaded_o); else pass_cnt++;
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL longwe_total: got %0d expected 1", wr_total - base); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_sel_race();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    send_byte(10'h008, 8'hB0, 4);
    send_byte(10'h009, 8'hB1, 4);
    jtag_addr_i = 10'h00A;
    jtag_data_i = 8'hB2;
    jtag_sel_i  = 1'b0;
    // two sync stages: we rises exactly when the FSM first sees sel low
    repeat (2) @(negedge clk);
    jtag_we_i = 1'b1;
    repeat (4) @(negedge clk);
    jtag_we_i = 1'b0;
    wait_writes(base + 1);
    chk_cnt++; if (log_addr[base] !== 8'h02) $display("FAIL race_addr: got %0h expected 2", log_addr[base]); else pass_cnt++;
    chk_cnt++; if (log_data[base] !== 32'h00B2_B1B0) $display("FAIL race_data: got %0h expected 00B2B1B0", log_data[base]); else pass_cnt++;
    wait_run(cyc);
    chk_cnt++; if (load_done_o !== 1'b1) $display("FAIL race_done: got %0h expected 1", load_done_o); else pass_cnt++;
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL race_count: got %0d expected 1", wr_total - base); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_skip();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    send_byte(10'h000, 8'hC0, 4);
    send_byte(10'h008, 8'hC8, 4);
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL skip_count: got %0d expected 1", wr_total - base); else pass_cnt++;
    chk_cnt++; if (log_data[base] !== 32'h0000_00C0) $display("FAIL skip_w0_data: got %0h expected 000000C0", log_data[base]); else pass_cnt++;
    jtag_sel_i = 1'b0;
    wait_writes(base + 2);
    chk_cnt++; if (log_addr[base+1] !== 8'h02) $display("FAIL skip_w1_addr: got %0h expected 2", log_addr[base+1]); else pass_cnt++;
    chk_cnt++; if (log_data[base+1] !== 32'h0000_00C8) $display("FAIL skip_w1_data: got %0h expected 000000C8", log_data[base+1]); else pass_cnt++;
    wait_run(cyc);
    chk_cnt++; if (words_loaded_o !== 9'd2) $display("FAIL skip_words: got %0d expected 2", words_loaded_o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    int base;
    base = wr_total;
    start_session();
    send_byte(10'h000, 8'hD0, 4);
    send_byte(10'h001, 8'hD1, 4);
    rst_i      = 1'b1;
    jtag_sel_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    wait_run(cyc);
    chk_cnt++; if (cyc !== 16) $display("FAIL midrst_hold_len: got %0d expected 16", cyc); else pass_cnt++;
    chk_cnt++; if (load_done_o !== 1'b0) $display("FAIL midrst_done: got %0h expected 0", load_done_o); else pass_cnt++;
    chk_cnt++; if (words_loaded_o !== 9'd0) $display("FAIL midrst_words: got %0d expected 0", words_loaded_o); else pass_cnt++;
    chk_cnt++; if (wr_total - base !== 0) $display("FAIL midrst_writes: got %0d expected 0", wr_total - base); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst_i       = 1'b1;
    jtag_sel_i  = 1'b0;
    jtag_we_i   = 1'b0;
    jtag_data_i = 8'h00;
    jtag_addr_i = '0;
    cpu_req_i   = 1'b0;
    cpu_addr_i  = '0;
    test_reset();
    test_full_word();
    test_partial_flush();
    test_long_we();
    test_sel_race();
    test_skip();
    test_reset_mid_load();
    @(negedge clk);
    chk_cnt++; if (dup_cnt !== 0) $display("FAIL dup_we: got %0d expected 0", dup_cnt); else pass_cnt++;
    chk_cnt++; if (run_wr_cnt !== 0) $display("FAIL we_in_run: got %0d expected 0", run_wr_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
